piece_queue: RTL and testbench



---
 rtl/piece_queue.sv | 121 ++++++++++++
 tb/tb_piece_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_queue.sv
// piece_queue: next-piece FIFO between the random piece generator and the game
// controller. Keeps DEPTH slots filled through the generator START/DONE
// handshake, exposes the head piece plus a preview of every slot, and counts
// pieces dealt with a saturating counter.
module piece_queue #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic                 gen_start,
  input  logic                 gen_done,
  input  logic [2:0]           gen_piece,
  input  logic                 pop,
  output logic [2:0]           piece_out,
  output logic                 piece_valid,
  output logic [3*DEPTH-1:0]   preview,
  output logic [2:0]           count,
  output logic [CNT_W-1:0]     dealt
);

  localparam logic [2:0] NONE    = 3'd7;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [2:0]       r_slot   [DEPTH];
  logic [2:0]       w_slot_d [DEPTH];
  logic [2:0]       r_count;
  logic [2:0]       w_count_mid;
  logic [2:0]       w_count_d;
  logic [CNT_W-1:0] r_dealt;
  logic [CNT_W-1:0] w_dealt_d;
  logic             w_pop_ok;
  logic             w_capture;
  logic             w_push;

  // A pop on an empty queue is ignored; a captured 7 is dropped but still
  // completes the handshake.
  assign w_pop_ok  = pop && (r_count != 3'd0);
  assign w_capture = (r_state == StReq) && gen_done;
  assign w_push    = w_capture && (gen_piece != NONE);

  // Request FSM next state: request whenever the registered count shows room.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (r_count < DEPTH_C) w_state_d = StReq;
      StReq:     if (gen_done) w_state_d = StRelease;
      StRelease: if (!gen_done) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Moore output: START is asserted only while waiting in StReq.
  assign gen_start = (r_state == StReq);

  // Slot next state: shift on pop first, then write the new piece at the
  // post-shift fill level. A request is only issued with a free slot and
  // count cannot rise until capture, so the write index is always in range.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_d[i] = r_slot[i];
    end
    if (w_pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_slot_d[i] = r_slot[i + 1];
      end
      w_slot_d[DEPTH-1] = NONE;
    end
    w_count_mid = r_count - {2'b00, w_pop_ok};
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (3'(i) == w_count_mid) w_slot_d[i] = gen_piece;
      end
    end
    w_count_d = w_count_mid + {2'b00, w_push};
  end

  // Dealt counter next state: +1 per accepted pop, sticking at all ones.
  always_comb begin
    w_dealt_d = r_dealt;
    if (w_pop_ok && (r_dealt != {CNT_W{1'b1}})) begin
      w_dealt_d = r_dealt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset aborts any handshake in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= StIdle;
      r_count <= 3'd0;
      r_dealt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= NONE;
      end
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_dealt <= w_dealt_d;
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= w_slot_d[i];
      end
    end
  end

  // Outputs are straight views of the registered slots.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      preview[3*i +: 3] = r_slot[i];
    end
  end

  assign piece_out   = r_slot[0];
  assign piece_valid = (r_count != 3'd0);
  assign count       = r_count;
  assign dealt       = r_dealt;

endmodule

// File: tb/tb_piece_queue.sv
// Scoreboard bench for piece_queue: a generator model feeds scripted pieces,
// stimulus pushes the expected head value of each accepted pop into a queue,
// and a monitor compares it when the pop is presented. Static state is checked
// directly against hand-computed values.
module tb_piece_queue;

  logic       CLK;
  logic       RESET;
  logic       gen_start;
  logic       gen_done;
  logic [2:0] gen_piece;
  logic       pop;
  logic [2:0] piece_out;
  logic       piece_valid;
  logic [8:0] preview;
  logic [2:0] count;
  logic [15:0] dealt;

  // Narrow-counter instance for the saturation check.
  logic       s_start;
  logic       s_done;
  logic       s_pop;
  logic [2:0] s_piece_out;
  logic       s_valid;
  logic [8:0] s_preview;
  logic [2:0] s_count;
  logic [1:0] s_dealt;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;
  logic [2:0] seq_q [$];
  logic [2:0] exp_q [$];

  piece_queue #(.DEPTH(3), .CNT_W(16)) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .gen_start   (gen_start),
    .gen_done    (gen_done),
    .gen_piece   (gen_piece),
    .pop         (pop),
    .piece_out   (piece_out),
    .piece_valid (piece_valid),
    .preview     (preview),
    .count       (count),
    .dealt       (dealt)
  );

  assign s_done = s_start;

  piece_queue #(.DEPTH(3), .CNT_W(2)) u_sat (
    .CLK         (CLK),
    .RESET       (RESET),
    .gen_start   (s_start),
    .gen_done    (s_done),
    .gen_piece   (3'd3),
    .pop         (s_pop),
    .piece_out   (s_piece_out),
    .piece_valid (s_valid),
    .preview     (s_preview),
    .count       (s_count),
    .dealt       (s_dealt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge gen_start) n_start++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Generator model: DONE a couple of cycles after START, held until START
  // drops. With nothing scripted it stalls, leaving the queue waiting in REQ.
  initial begin : gen_model
    int cnt;
    cnt = 0;
    gen_done = 1'b0;
    gen_piece = 3'd7;
    forever begin
      @(posedge CLK);
      #1;
      if (RESET) begin
        gen_done = 1'b0;
        cnt = 0;
      end else if (gen_done) begin
        if (!gen_start) gen_done = 1'b0;
      end else if (gen_start) begin
        if (cnt < 2) cnt++;
        else if (seq_q.size() > 0) begin
          gen_piece = seq_q.pop_front();
          gen_done = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every accepted pop must present the next expected head piece.
  always @(negedge CLK) begin
    if (!RESET && pop && piece_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_head: got %0d expected no pop accepted", piece_out);
      end else begin
        chk("pop_head", {29'd0, piece_out}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_pop(input logic [2:0] exp);
    exp_q.push_back(exp);
    @(posedge CLK);
    #1 pop = 1'b1;
    @(posedge CLK);
    #1 pop = 1'b0;
  endtask

  task automatic wait_count(input logic [2:0] target, input int budget, input string nm);
    int n;
    n = 0;
    while (count !== target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, {29'd0, count}, {29'd0, target});
  endtask

  task automatic sat_pop(input logic [1:0] exp, input string nm);
    @(posedge CLK);
    #1 s_pop = 1'b1;
    @(posedge CLK);
    #1 s_pop = 1'b0;
    @(negedge CLK);
    chk(nm, {30'd0, s_dealt}, {30'd0, exp});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int n;
    RESET = 1'b1;
    pop   = 1'b0;
    s_pop = 1'b0;
    seq_q.push_back(3'd4);
    seq_q.push_back(3'd1);
    seq_q.push_back(3'd6);
    repeat (3) @(negedge CLK);
    chk("rst_gen_start", {31'd0, gen_start}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, piece_valid}, 32'd0);
    chk("rst_piece_out", {29'd0, piece_out}, 32'd7);
    chk("rst_preview", {23'd0, preview}, 32'h1FF);
    chk("rst_dealt", {16'd0, dealt}, 32'd0);

    // 1: initial fill 4,1,6 takes exactly three requests.
    RESET = 1'b0;
    wait_count(3'd3, 60, "fill_count");
    repeat (10) @(negedge CLK);
    chk("fill_starts", n_start, 32'd3);
    chk("fill_gen_start_low", {31'd0, gen_start}, 32'd0);
    chk("fill_preview", {23'd0, preview}, {23'd0, 3'd6, 3'd1, 3'd4});
    chk("fill_piece_out", {29'd0, piece_out}, 32'd4);
    chk("fill_valid", {31'd0, piece_valid}, 32'd1);

    // 2: single pop, then refill with 2 into the top slot.
    seq_q.push_back(3'd2);
    do_pop(3'd4);
    @(negedge CLK);
    chk("pop1_piece_out", {29'd0, piece_out}, 32'd1);
    chk("pop1_count", {29'd0, count}, 32'd2);
    chk("pop1_dealt", {16'd0, dealt}, 32'd1);
    chk("pop1_slot2", {29'd0, preview[8:6]}, 32'd7);
    n = 0;
    while (!gen_start && n < 2) begin
      @(negedge CLK);
      n++;
    end
    chk("pop1_restart", {31'd0, gen_start}, 32'd1);
    wait_count(3'd3, 40, "refill_count");
    chk("refill_preview", {23'd0, preview}, {23'd0, 3'd2, 3'd6, 3'd1});

    // 3: drain, build {3,0}, then pop on the same edge 5 is captured.
    do_pop(3'd1);
    do_pop(3'd6);
    do_pop(3'd2);
    @(negedge CLK);
    chk("drain_count", {29'd0, count}, 32'd0);
    seq_q.push_back(3'd3);
    wait_count(3'd1, 40, "build1_count");
    seq_q.push_back(3'd0);
    wait_count(3'd2, 40, "build2_count");
    repeat (6) @(negedge CLK);
    chk("build_preview", {23'd0, preview}, {23'd0, 3'd7, 3'd0, 3'd3});
    seq_q.push_back(3'd5);
    do_pop(3'd3);
    @(negedge CLK);
    chk("simul_preview", {23'd0, preview}, {23'd0, 3'd7, 3'd5, 3'd0});
    chk("simul_count", {29'd0, count}, 32'd2);
    chk("simul_piece_out", {29'd0, piece_out}, 32'd0);
    chk("simul_dealt", {16'd0, dealt}, 32'd5);

    // 4: a returned 7 is discarded and re-requested; empty pop is ignored.
    repeat (6) @(negedge CLK);
    base = n_start;
    seq_q.push_back(3'd7);
    repeat (8) @(negedge CLK);
    chk("none_count", {29'd0, count}, 32'd2);
    chk("none_preview", {23'd0, preview}, {23'd0, 3'd7, 3'd5, 3'd0});
    chk("none_restarts", n_start - base, 32'd1);
    chk("none_gen_start", {31'd0, gen_start}, 32'd1);
    do_pop(3'd0);
    do_pop(3'd5);
    @(posedge CLK);
    #1 pop = 1'b1;
    @(posedge CLK);
    #1 pop = 1'b0;
    @(negedge CLK);
    chk("empty_pop_count", {29'd0, count}, 32'd0);
    chk("empty_pop_dealt", {16'd0, dealt}, 32'd7);
    chk("empty_pop_valid", {31'd0, piece_valid}, 32'd0);

    // 5: asynchronous reset while waiting in REQ.
    seq_q.push_back(3'd2);
    wait_count(3'd1, 40, "prerst_count");
    repeat (6) @(negedge CLK);
    chk("prerst_gen_start", {31'd0, gen_start}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_gen_start", {31'd0, gen_start}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_piece_out", {29'd0, piece_out}, 32'd7);
    chk("arst_dealt", {16'd0, dealt}, 32'd0);
    repeat (2) @(negedge CLK);
    seq_q.push_back(3'd5);
    seq_q.push_back(3'd3);
    seq_q.push_back(3'd1);
    RESET = 1'b0;
    wait_count(3'd3, 60, "postrst_count");
    chk("postrst_preview", {23'd0, preview}, {23'd0, 3'd1, 3'd3, 3'd5});
    chk("postrst_dealt", {16'd0, dealt}, 32'd0);

    // 6: saturation on a 2-bit dealt counter: 1, 2, 3, then holds at 3.
    repeat (10) @(negedge CLK);
    chk("sat_count_full", {29'd0, s_count}, 32'd3);
    sat_pop(2'd1, "sat_dealt1");
    sat_pop(2'd2, "sat_dealt2");
    sat_pop(2'd3, "sat_dealt3");
    sat_pop(2'd3, "sat_hold1");
    sat_pop(2'd3, "sat_hold2");

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
